vram_read_arbiter: RTL and testbench

//  Shares one pipelined video-memory read port among NUM_REQ requesters.

---
 rtl/vram_read_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_read_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_read_arbiter.sv
// Shares one pipelined video-memory read port among NUM_REQ requesters.
// Port 0 (scanout) has priority; ports 1..N-1 are served round-robin with a starvation guard.

module vram_wait_cnt #(
  parameter int MAX_WAIT = 15,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic starved
);
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (req && !gnt)
      cnt_d = (cnt_q == CW'(MAX_WAIT)) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign starved = req && (cnt_q == CW'(MAX_WAIT));
endmodule

module vram_read_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  input  logic                      mem_ready_i,
  output logic                      mem_rd_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  input  logic [DATA_W-1:0]         mem_data_i
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CW    = $clog2(MAX_WAIT + 1);

  if (NUM_REQ < 2 || MEM_LATENCY < 1 || MAX_WAIT < 1) begin : g_bad_param
    $error("vram_read_arbiter: NUM_REQ>=2, MEM_LATENCY>=1, MAX_WAIT>=1 required");
  end

  logic [NUM_REQ-1:0][ADDR_W-1:0]      addr_v;
  logic [NUM_REQ-1:0]                  starved, gnt;
  logic [PTR_W-1:0]                    rr_q, rr_d;
  logic                                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]                   mem_addr_q, mem_addr_d;
  logic [MEM_LATENCY:0][NUM_REQ-1:0]   vld_pipe_q, vld_pipe_d;

  assign addr_v = addr_i;

  // First set bit of v among ports 1..N-1, scanning from ptr and wrapping N-1 -> 1.
  function automatic logic [NUM_REQ-1:0] pick_rr(input logic [NUM_REQ-1:0] v,
                                                 input logic [PTR_W-1:0]   ptr);
    logic [NUM_REQ-1:0] oh;
    logic [PTR_W:0]     s;
    logic [PTR_W-1:0]   idx;
    logic               done;
    oh   = '0;
    done = 1'b0;
    for (int i = 0; i < NUM_REQ-1; i++) begin
      s = {1'b0, ptr} + (PTR_W+1)'(i);
      if (s > (PTR_W+1)'(NUM_REQ-1)) s = s - (PTR_W+1)'(NUM_REQ-1);
      idx = s[PTR_W-1:0];
      if (!done && v[idx]) begin
        oh[idx] = 1'b1;
        done    = 1'b1;
      end
    end
    return oh;
  endfunction

  assign starved[0] = 1'b0;
  for (genvar k = 1; k < NUM_REQ; k++) begin : g_wait
    vram_wait_cnt #(.MAX_WAIT(MAX_WAIT), .CW(CW)) u_wait (
      .clk     (clk),
      .reset   (reset),
      .req     (req_i[k]),
      .gnt     (gnt[k]),
      .starved (starved[k])
    );
  end

  always_comb begin
    gnt = '0;
    if (mem_ready_i) begin
      if (|starved)       gnt = pick_rr(starved, rr_q);
      else if (req_i[0])  gnt[0] = 1'b1;
      else                gnt = pick_rr({req_i[NUM_REQ-1:1], 1'b0}, rr_q);
    end
  end

  always_comb begin
    rr_d       = rr_q;
    mem_addr_d = mem_addr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        mem_addr_d = addr_v[k];
        if (k != 0) rr_d = (k == NUM_REQ-1) ? PTR_W'(1) : PTR_W'(k+1);
      end
    end
    mem_rd_d   = |gnt;
    // Stage 0 travels alongside the issued strobe; the last stage lines up with returning data.
    vld_pipe_d = {vld_pipe_q[MEM_LATENCY-1:0], gnt};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q       <= PTR_W'(1);
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      vld_pipe_q <= '0;
    end else begin
      rr_q       <= rr_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign gnt_o      = gnt;
  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = mem_addr_q;
  assign rvalid_o   = vld_pipe_q[MEM_LATENCY];
  assign rdata_o    = mem_data_i;
endmodule

// File: tb/tb_vram_read_arbiter.sv
// Bench for vram_read_arbiter: scenario tasks plus random traffic against a cycle-level
// reference model of the priority / round-robin / starvation rules and return timing.

module tb_vram_read_arbiter;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int L  = 2;
  localparam int MW = 15;
  localparam int VW = 2*N + 1 + AW + DW;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [AW-1:0] addr [N];
  logic [N*AW-1:0] addr_flat;
  logic          ready;
  logic [N-1:0]  gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o, mem_data;
  logic          mem_rd_o;
  logic [AW-1:0] mem_addr_o;

  always #5 clk = ~clk;

  always_comb begin
    addr_flat = '0;
    for (int k = 0; k < N; k++) addr_flat[k*AW +: AW] = addr[k];
  end

  vram_read_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .addr_i     (addr_flat),
    .gnt_o      (gnt_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .mem_ready_i(ready),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_i (mem_data)
  );

  // Memory: fixed latency, data = {A5A5, addr}
  logic          mv [L];
  logic [AW-1:0] ma [L];
  always @(posedge clk) begin
    mv[0] <= mem_rd_o;
    ma[0] <= mem_addr_o;
    for (int i = 1; i < L; i++) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
    end
  end
  assign mem_data = mv[L-1] ? {16'hA5A5, ma[L-1]} : 32'h0;

  // Reference model
  int            wcnt [N];
  int            rr;
  int            cyc;
  int            sched_port [int];
  logic [AW-1:0] sched_addr [int];
  logic          prev_rd;
  logic [AW-1:0] prev_addr;
  int            exp_g;
  logic [N-1:0]  exp_gnt, exp_rv;
  logic [VW-1:0] exp_vec;
  int            n_cmp = 0;
  int            n_err = 0;

  function automatic logic [VW-1:0] obs();
    return {gnt_o, rvalid_o, mem_rd_o, mem_rd_o ? mem_addr_o : {AW{1'b0}},
            (|rvalid_o) ? rdata_o : {DW{1'b0}}};
  endfunction

  task automatic model_eval();
    logic [DW-1:0] d;
    @(negedge clk);
    exp_g = -1;
    if (ready) begin
      for (int i = 0; i < N-1; i++) begin
        int k = ((rr - 1 + i) % (N-1)) + 1;
        if (exp_g < 0 && req[k] && wcnt[k] == MW) exp_g = k;
      end
      if (exp_g < 0 && req[0]) exp_g = 0;
      for (int i = 0; i < N-1; i++) begin
        int k = ((rr - 1 + i) % (N-1)) + 1;
        if (exp_g < 0 && req[k]) exp_g = k;
      end
    end
    exp_gnt = '0;
    if (exp_g >= 0) exp_gnt[exp_g] = 1'b1;
    exp_rv = '0;
    d = '0;
    if (sched_port.exists(cyc)) begin
      exp_rv[sched_port[cyc]] = 1'b1;
      d = {16'hA5A5, sched_addr[cyc]};
    end
    exp_vec = {exp_gnt, exp_rv, prev_rd, prev_rd ? prev_addr : {AW{1'b0}}, d};
  endtask

  task automatic model_step();
    @(posedge clk);
    #1;
    if (reset) begin
      for (int k = 0; k < N; k++) wcnt[k] = 0;
      rr = 1;
      sched_port.delete();
      sched_addr.delete();
      prev_rd = 1'b0;
      prev_addr = '0;
    end else begin
      for (int k = 1; k < N; k++)
        wcnt[k] = (req[k] && exp_g != k) ? ((wcnt[k] < MW) ? wcnt[k] + 1 : MW) : 0;
      if (exp_g >= 1) rr = (exp_g % (N-1)) + 1;
      prev_rd = (exp_g >= 0);
      if (exp_g >= 0) begin
        prev_addr = addr[exp_g];
        sched_port[cyc+1+L] = exp_g;
        sched_addr[cyc+1+L] = addr[exp_g];
        addr[exp_g] = 16'($urandom);
      end
    end
    cyc++;
  endtask

  task automatic drain();
    req = '0;
    ready = 1'b1;
    repeat (L + 3) begin
      model_eval();
      model_step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      model_eval();
      model_step();
    end
    reset = 1'b0;
    model_eval();
    n_cmp++;
    if ({gnt_o, rvalid_o, mem_rd_o, mem_addr_o} !== '0) begin
      n_err++;
      $display("FAIL reset_state got %h want 0", {gnt_o, rvalid_o, mem_rd_o, mem_addr_o});
    end
    n_cmp++;
    if (obs() !== exp_vec) begin
      n_err++;
      $display("FAIL reset_model cyc%0d got %h want %h", cyc, obs(), exp_vec);
    end
    model_step();
  endtask

  task automatic test_single();
    req = 3'b010;
    addr[1] = 16'h1234;
    for (int t = 0; t < 5; t++) begin
      model_eval();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_err++;
        $display("FAIL single cyc%0d got %h want %h", cyc, obs(), exp_vec);
      end
      if (t == 0) begin
        n_cmp++;
        if (gnt_o !== 3'b010) begin n_err++; $display("FAIL single_gnt got %b want 010", gnt_o); end
      end
      if (t == 1) begin
        n_cmp++;
        if ({mem_rd_o, mem_addr_o} !== {1'b1, 16'h1234}) begin
          n_err++;
          $display("FAIL single_issue got %b/%h want 1/1234", mem_rd_o, mem_addr_o);
        end
      end
      if (t == 3) begin
        n_cmp++;
        if ({rvalid_o, rdata_o} !== {3'b010, 32'hA5A51234}) begin
          n_err++;
          $display("FAIL single_return got %b/%h want 010/a5a51234", rvalid_o, rdata_o);
        end
      end
      model_step();
      if (t == 0) req = '0;
    end
  endtask

  task automatic test_round_robin();
    int p1 = 0;
    req = 3'b110;
    for (int t = 0; t < 12 + L + 2; t++) begin
      if (t == 12) req = '0;
      model_eval();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_err++;
        $display("FAIL round_robin cyc%0d got %h want %h", cyc, obs(), exp_vec);
      end
      if (gnt_o[1]) p1++;
      model_step();
    end
    n_cmp++;
    if (p1 !== 6) begin n_err++; $display("FAIL rr_share got %0d want 6", p1); end
  endtask

  task automatic test_starvation();
    int cnt = 0;
    int first = -1;
    req = 3'b011;
    for (int t = 0; t < 40; t++) begin
      model_eval();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_err++;
        $display("FAIL starvation cyc%0d got %h want %h", cyc, obs(), exp_vec);
      end
      if (gnt_o[1]) begin
        cnt++;
        if (first < 0) first = t;
      end
      model_step();
    end
    n_cmp++;
    if (first !== 15 || cnt !== 2) begin
      n_err++;
      $display("FAIL starve_slot got first=%0d n=%0d want first=15 n=2", first, cnt);
    end
    drain();
  endtask

  task automatic test_stall();
    req = 3'b111;
    ready = 1'b0;
    for (int t = 0; t < 12; t++) begin
      if (t == 5) ready = 1'b1;
      model_eval();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_err++;
        $display("FAIL stall cyc%0d got %h want %h", cyc, obs(), exp_vec);
      end
      if (t < 5) begin
        n_cmp++;
        if ({gnt_o, mem_rd_o} !== 4'b0) begin
          n_err++;
          $display("FAIL stall_idle got %b/%b want 000/0", gnt_o, mem_rd_o);
        end
      end
      if (t == 5) begin
        n_cmp++;
        if (gnt_o !== 3'b001) begin n_err++; $display("FAIL stall_release got %b want 001", gnt_o); end
      end
      model_step();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int nrv = 0;
    req = 3'b110;
    for (int t = 0; t < 7; t++) begin
      if (t == 2) begin req = '0; reset = 1'b1; end
      if (t == 3) reset = 1'b0;
      model_eval();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_err++;
        $display("FAIL reset_mid cyc%0d got %h want %h", cyc, obs(), exp_vec);
      end
      if (t == 3) begin
        n_cmp++;
        if ({gnt_o, rvalid_o, mem_rd_o, mem_addr_o} !== '0) begin
          n_err++;
          $display("FAIL reset_mid_clear got %h want 0", {gnt_o, rvalid_o, mem_rd_o, mem_addr_o});
        end
      end
      if (t >= 3 && |rvalid_o) nrv++;
      model_step();
    end
    n_cmp++;
    if (nrv !== 0) begin n_err++; $display("FAIL reset_mid_rvalid got %0d want 0", nrv); end
  endtask

  task automatic test_drop();
    int first = -1;
    for (int t = 0; t < 31; t++) begin
      req = (t == 10) ? 3'b001 : 3'b101;
      model_eval();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_err++;
        $display("FAIL drop cyc%0d got %h want %h", cyc, obs(), exp_vec);
      end
      if (gnt_o[2] && first < 0) first = t - 11;
      model_step();
    end
    n_cmp++;
    if (first !== 15) begin n_err++; $display("FAIL drop_restart got %0d want 15", first); end
    drain();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      ready = ($urandom_range(0, 3) != 0);
      model_eval();
      n_cmp++;
      if (obs() !== exp_vec) begin
        n_err++;
        $display("FAIL random cyc%0d got %h want %h", cyc, obs(), exp_vec);
      end
      model_step();
      for (int k = 0; k < N; k++) begin
        if (!req[k] || exp_g == k) begin
          req[k] = (k == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) < 7);
          addr[k] = 16'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
        end
      end
    end
    drain();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      addr[k] = '0;
      wcnt[k] = 0;
    end
    rr = 1;
    cyc = 0;
    prev_rd = 1'b0;
    prev_addr = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_stall();
    test_reset_mid();
    test_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
